// File: rtl/id_stage.sv
// id_stage: RV32I decode / operand-fetch stage for OP and OP-IMM formats.
// Holds the 32-entry register file (with a write-back port) and the ID/EX
// pipeline register that drives the ALU operand and function inputs.
//
// Handshake (both sides are strict valid/ready): a transfer happens on a
// rising edge where valid && ready are both high. Once valid is raised, the
// payload stays stable until the transfer. Upstream: instr_valid/instr_ready.
// Downstream: ex_valid/ex_ready. instr_ready = !ex_valid || ex_ready, so the
// stage accepts a new instruction only when the ID/EX slot is empty or is
// being drained in the same cycle.
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_rs2,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_we,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_idx;

  assign opcode  = instr[6:0];
  assign rd_idx  = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign funct7  = instr[31:25];

  logic accept;
  assign instr_ready = !ex_valid || ex_ready;
  assign accept      = instr_valid && instr_ready;

  // Register file write port; x0 is never written so it always stays zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  // Source reads with same-cycle write-back bypass; x0 reads as zero.
  always_comb begin
    rs1_val = regs[rs1_idx];
    rs2_val = regs[rs2_idx];
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs1_idx)) rs1_val = wb_data;
    if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs2_idx)) rs2_val = wb_data;
    if (rs1_idx == 5'd0) rs1_val = '0;
    if (rs2_idx == 5'd0) rs2_val = '0;
  end

  logic            dec_legal;
  logic [XLEN-1:0] dec_rs2;
  logic [6:0]      dec_f7;

  // Format decode: legality, operand B selection and the funct7 seen by the ALU.
  always_comb begin
    dec_legal = 1'b0;
    dec_rs2   = '0;
    dec_f7    = 7'h00;
    case (opcode)
      OPC_OP: begin
        if ((funct7 == 7'h00) ||
            ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          dec_legal = 1'b1;
          dec_rs2   = rs2_val;
          dec_f7    = funct7;
        end
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b001: begin
            if (funct7 == 7'h00) begin
              dec_legal = 1'b1;
              dec_rs2   = {{(XLEN-5){1'b0}}, instr[24:20]};
            end
          end
          3'b101: begin
            if ((funct7 == 7'h00) || (funct7 == 7'h20)) begin
              dec_legal = 1'b1;
              dec_rs2   = {{(XLEN-5){1'b0}}, instr[24:20]};
              dec_f7    = funct7;
            end
          end
          default: begin
            // Immediate arithmetic/logic never reports funct7=0x20 to the ALU.
            dec_legal = 1'b1;
            dec_rs2   = {{(XLEN-12){instr[31]}}, instr[31:20]};
          end
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // ID/EX pipeline register: load on accept, drain on consume, hold on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_funct3  <= 3'd0;
      ex_funct7  <= 7'd0;
      ex_rd_addr <= 5'd0;
      ex_we      <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      ex_rs1     <= dec_legal ? rs1_val : '0;
      ex_rs2     <= dec_rs2;
      ex_funct3  <= dec_legal ? funct3 : 3'd0;
      ex_funct7  <= dec_f7;
      ex_rd_addr <= rd_idx;
      ex_we      <= dec_legal && (rd_idx != 5'd0);
      ex_illegal <= !dec_legal;
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage.
module tb_id_stage;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [2:0]      ex_funct3;
  logic [6:0]      ex_funct7;
  logic [4:0]      ex_rd_addr;
  logic            ex_we;
  logic            ex_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  id_stage #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_rd_addr(ex_rd_addr), .ex_we(ex_we), .ex_illegal(ex_illegal)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Driver: one write-back cycle. Inputs change on negedge, DUT samples posedge.
  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk); @(negedge clk);
    wb_en = 1'b0;
  endtask

  // Driver: present one instruction for a single cycle (slot assumed free).
  task automatic issue(input logic [31:0] w);
    instr_valid = 1'b1; instr = w;
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic check_ex(input string tag, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                          input logic we, input logic ill);
    check({tag, ".valid"}, {31'd0, ex_valid}, 32'd1);
    check({tag, ".rs1"}, ex_rs1, rs1);
    check({tag, ".rs2"}, ex_rs2, rs2);
    check({tag, ".f3"}, {29'd0, ex_funct3}, {29'd0, f3});
    check({tag, ".f7"}, {25'd0, ex_funct7}, {25'd0, f7});
    check({tag, ".rd"}, {27'd0, ex_rd_addr}, {27'd0, rd});
    check({tag, ".we"}, {31'd0, ex_we}, {31'd0, we});
    check({tag, ".ill"}, {31'd0, ex_illegal}, {31'd0, ill});
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.valid", {31'd0, ex_valid}, 32'd0);
    check("rst.rs1", ex_rs1, 32'd0);
    check("rst.rs2", ex_rs2, 32'd0);
    check("rst.we", {31'd0, ex_we}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst.ready", {31'd0, instr_ready}, 32'd1);

    // ADD x3,x1,x2
    wb_write(5'd1, 32'd20);
    wb_write(5'd2, 32'd30);
    issue(32'h002081B3);
    check_ex("add", 32'd20, 32'd30, 3'd0, 7'h00, 5'd3, 1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    check("add.drain", {31'd0, ex_valid}, 32'd0);

    // SUB x3,x1,x2
    wb_write(5'd1, 32'd8);
    wb_write(5'd2, 32'd3);
    issue(32'h402081B3);
    check_ex("sub", 32'd8, 32'd3, 3'd0, 7'h20, 5'd3, 1'b1, 1'b0);

    // ADDI x5,x1,-1
    issue(32'hFFF08293);
    check_ex("addi", 32'd8, 32'hFFFFFFFF, 3'd0, 7'h00, 5'd5, 1'b1, 1'b0);

    // SRAI x6,x1,3
    issue(32'h4030D313);
    check_ex("srai", 32'd8, 32'd3, 3'd5, 7'h20, 5'd6, 1'b1, 1'b0);

    // SLLI x7,x1,4 (0x00409393)
    issue(32'h00409393);
    check_ex("slli", 32'd8, 32'd4, 3'd1, 7'h00, 5'd7, 1'b1, 1'b0);

    // Write-back coincident with accept: bypass delivers the new x1
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
    issue(32'h002081B3);
    wb_en = 1'b0;
    check_ex("bypass", 32'h55, 32'd3, 3'd0, 7'h00, 5'd3, 1'b1, 1'b0);

    // x0 stays zero, both via register write and via bypass
    wb_write(5'd0, 32'hFF);
    issue(32'h000001B3);
    check_ex("x0", 32'd0, 32'd0, 3'd0, 7'h00, 5'd3, 1'b1, 1'b0);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
    issue(32'h000001B3);
    wb_en = 1'b0;
    check("x0byp.rs1", ex_rs1, 32'd0);

    // ADD with rd=x0: legal but not written back (0x00208033)
    issue(32'h00208033);
    check_ex("rd0", 32'h55, 32'd3, 3'd0, 7'h00, 5'd0, 1'b0, 1'b0);

    // Backpressure
    ex_ready = 1'b0;
    issue(32'h002081B3);
    check("bp.load.rs1", ex_rs1, 32'h55);
    instr_valid = 1'b1; instr = 32'h402081B3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp.ready", {31'd0, instr_ready}, 32'd0);
      check("bp.valid", {31'd0, ex_valid}, 32'd1);
      check("bp.rs1", ex_rs1, 32'h55);
      check("bp.f7", {25'd0, ex_funct7}, 32'd0);
    end
    ex_ready = 1'b1;
    #1;
    check("bp.ready_up", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    instr_valid = 1'b0;
    check_ex("bp.next", 32'h55, 32'd3, 3'd0, 7'h20, 5'd3, 1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    check("bp.nodup", {31'd0, ex_valid}, 32'd0);

    // Illegal encodings
    issue(32'h0000007F);
    check_ex("ill.opc", 32'd0, 32'd0, 3'd0, 7'h00, 5'd0, 1'b0, 1'b1);
    issue(32'h022081B3);
    check_ex("ill.f7", 32'd0, 32'd0, 3'd0, 7'h00, 5'd3, 1'b0, 1'b1);
    issue(32'h4020C1B3);   // XOR with funct7=0x20
    check_ex("ill.f7x", 32'd0, 32'd0, 3'd0, 7'h00, 5'd3, 1'b0, 1'b1);
    issue(32'h6030D313);   // SRAI-style with funct7=0x30
    check_ex("ill.sh", 32'd0, 32'd0, 3'd0, 7'h00, 5'd6, 1'b0, 1'b1);

    // Reset while holding an instruction
    ex_ready = 1'b0;
    issue(32'h002081B3);
    check("rst2.pre", {31'd0, ex_valid}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst2.valid", {31'd0, ex_valid}, 32'd0);
    check("rst2.rs1", ex_rs1, 32'd0);
    rst_n = 1'b1; ex_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    issue(32'h002081B3);
    check_ex("rst2.rf", 32'd0, 32'd0, 3'd0, 7'h00, 5'd3, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
